// File: rtl/decoder_nto2n_hold.sv
// Registered N-to-2^N one-hot decoder with valid/ready intake and a timed hold window.
// Optional sel/en parity checking is enabled by defining DECODER_PARITY_EN.
module decoder_nto2n_hold #(
  parameter int SEL_W       = 3,
  parameter int HOLD_CYCLES = 2,
  parameter int ACTIVE_LOW  = 1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SEL_W-1:0]      sel,
  input  logic                  en,
`ifdef DECODER_PARITY_EN
  input  logic                  sel_par,
  output logic                  par_err,
`endif
  output logic [2**SEL_W-1:0]   y,
  output logic                  busy,
  output logic                  done
);

  localparam int N  = 2**SEL_W;
  localparam int CW = $clog2(HOLD_CYCLES + 1);
  localparam logic [N-1:0]  INACT  = (ACTIVE_LOW != 0) ? {N{1'b1}} : {N{1'b0}};
  localparam logic [CW-1:0] RELOAD = CW'(HOLD_CYCLES - 1);

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [N-1:0] act_pattern(input logic [SEL_W-1:0] s);
    logic [N-1:0] onehot;
    onehot = {{(N-1){1'b0}}, 1'b1} << s;
    return (ACTIVE_LOW != 0) ? ~onehot : onehot;
  endfunction

  function automatic logic even_parity(input logic e, input logic [SEL_W-1:0] s);
    return ^{e, s};
  endfunction

  state_t         state_r, state_s;
  logic [CW-1:0]  cnt_r, cnt_s;
  logic [N-1:0]   y_r, y_s;
  logic           busy_r, busy_s;
  logic           done_r, done_s;
  logic           par_err_r, par_err_s;
  logic           accept_s, par_ok_s, go_s;

  // Parity qualifier; without the option every accepted request is trusted.
  always_comb begin
`ifdef DECODER_PARITY_EN
    par_ok_s = (sel_par == even_parity(en, sel));
`else
    par_ok_s = 1'b1;
`endif
  end

  assign in_ready = (state_r == IDLE) || (cnt_r == {CW{1'b0}});
  assign accept_s = in_valid & in_ready;
  assign go_s     = accept_s & en & par_ok_s;

  // Next-state and next-output logic.
  always_comb begin
    state_s   = state_r;
    cnt_s     = cnt_r;
    y_s       = y_r;
    busy_s    = busy_r;
    done_s    = 1'b0;
    par_err_s = accept_s & ~par_ok_s;
    case (state_r)
      IDLE: begin
        if (go_s) begin
          y_s     = act_pattern(sel);
          cnt_s   = RELOAD;
          state_s = HOLD;
          busy_s  = 1'b1;
        end else if (accept_s) begin
          y_s     = INACT;
          busy_s  = 1'b0;
        end else begin
          y_s     = y_r;
        end
      end
      HOLD: begin
        if (cnt_r != {CW{1'b0}}) begin
          cnt_s = cnt_r - CW'(1);
        end else if (go_s) begin
          // Back-to-back: the ending window still reports done.
          y_s    = act_pattern(sel);
          cnt_s  = RELOAD;
          done_s = 1'b1;
        end else begin
          y_s     = INACT;
          state_s = IDLE;
          busy_s  = 1'b0;
          done_s  = 1'b1;
        end
      end
      default: begin
        y_s     = INACT;
        cnt_s   = {CW{1'b0}};
        state_s = IDLE;
        busy_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset overrides any same-cycle accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r   <= IDLE;
      cnt_r     <= {CW{1'b0}};
      y_r       <= INACT;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      par_err_r <= 1'b0;
    end else begin
      state_r   <= state_s;
      cnt_r     <= cnt_s;
      y_r       <= y_s;
      busy_r    <= busy_s;
      done_r    <= done_s;
      par_err_r <= par_err_s;
    end
  end

  assign y    = y_r;
  assign busy = busy_r;
  assign done = done_r;
`ifdef DECODER_PARITY_EN
  assign par_err = par_err_r;
`endif

endmodule
